// File: rtl/fetch_decode_queue_if.sv
// Fetch-to-decode queue handshake bundle: push side from fetch, pop side to decode,
// plus flush and occupancy reporting.
interface fetch_decode_queue_if #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  push_valid;
    logic                  push_ready;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pop_valid;
    logic                  pop_ready;
    logic [DATA_WIDTH-1:0] pop_data;
    logic                  flush;
    logic                  busy;
    logic [CNT_W-1:0]      occupancy;
    logic [CNT_W-1:0]      peak_occupancy;

    modport master (
        output push_valid, push_data, pop_ready, flush,
        input  push_ready, pop_valid, pop_data, busy, occupancy, peak_occupancy
    );

    modport slave (
        input  push_valid, push_data, pop_ready, flush,
        output push_ready, pop_valid, pop_data, busy, occupancy, peak_occupancy
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// DEPTH-entry valid/ready FIFO between fetch and decode, with flush on redirect
// and occupancy / high-water reporting.
module fetch_decode_queue #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_decode_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    logic [CNT_W-1:0]      peak;
    logic                  push_fire;
    logic                  pop_fire;

    // push_ready looks only at occupancy so pop_ready never reaches it combinationally
    assign bus.push_ready     = (count != FULL);
    assign bus.pop_valid      = (count != '0);
    assign bus.busy           = bus.pop_valid;
    assign bus.pop_data       = mem[rd_ptr];
    assign bus.occupancy      = count;
    assign bus.peak_occupancy = peak;

    assign push_fire = bus.push_valid & bus.push_ready;
    assign pop_fire  = bus.pop_valid & bus.pop_ready;

    always_comb begin
        count_next = count;
        if (bus.flush) begin
            count_next = '0;
        end else begin
            case ({push_fire, pop_fire})
                2'b10:   count_next = count + CNT_W'(1);
                2'b01:   count_next = count - CNT_W'(1);
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            peak   <= '0;
        end else begin
            count <= count_next;
            if (count_next > peak) begin
                peak <= count_next;
            end
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_fire) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop_fire) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Storage is left uninitialised on reset; occupancy gates its visibility.
    always_ff @(posedge clk) begin
        if (push_fire && !bus.flush) begin
            mem[wr_ptr] <= bus.push_data;
        end
    end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue (DATA_WIDTH=8, DEPTH=4).
module tb_fetch_decode_queue;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    fetch_decode_queue_if #(.DATA_WIDTH(8), .DEPTH(4)) bus ();

    fetch_decode_queue #(.DATA_WIDTH(8), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.push_valid = 1'b0;
        bus.push_data  = '0;
        bus.pop_ready  = 1'b0;
        bus.flush      = 1'b0;
        #3;
        check("rst_push_ready", bus.push_ready, 1);
        check("rst_pop_valid", bus.pop_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_occ", bus.occupancy, 0);
        check("rst_peak", bus.peak_occupancy, 0);
        @(negedge clk);
        reset = 1'b0;

        // single push, one-cycle latency
        bus.push_valid = 1'b1;
        bus.push_data  = 8'h11;
        tick();
        bus.push_valid = 1'b0;
        check("t1_pop_valid", bus.pop_valid, 1);
        check("t1_pop_data", bus.pop_data, 8'h11);
        check("t1_occ", bus.occupancy, 1);
        check("t1_busy", bus.busy, 1);
        bus.pop_ready = 1'b1;
        tick();
        bus.pop_ready = 1'b0;
        check("t1_drained", bus.pop_valid, 0);

        // fill, overfill ignored, drain in order
        for (int i = 0; i < 4; i++) begin
            bus.push_valid = 1'b1;
            bus.push_data  = 8'hA0 + 8'(i);
            tick();
        end
        check("t2_occ_full", bus.occupancy, 4);
        check("t2_push_ready", bus.push_ready, 0);
        bus.push_data = 8'hA4;
        tick();
        bus.push_valid = 1'b0;
        check("t2_occ_after_overfill", bus.occupancy, 4);
        for (int i = 0; i < 4; i++) begin
            check("t2_pop_valid", bus.pop_valid, 1);
            check("t2_pop_data", bus.pop_data, 8'hA0 + 8'(i));
            bus.pop_ready = 1'b1;
            tick();
        end
        bus.pop_ready = 1'b0;
        check("t2_empty", bus.pop_valid, 0);
        check("t2_occ_zero", bus.occupancy, 0);

        // push while full with simultaneous pop is not admitted
        for (int i = 0; i < 4; i++) begin
            bus.push_valid = 1'b1;
            bus.push_data  = 8'hB0 + 8'(i);
            tick();
        end
        bus.push_data = 8'hC0;
        bus.pop_ready = 1'b1;
        tick();
        bus.push_valid = 1'b0;
        bus.pop_ready  = 1'b0;
        check("t3_occ", bus.occupancy, 3);
        check("t3_head", bus.pop_data, 8'hB1);
        for (int i = 1; i < 4; i++) begin
            check("t3_pop_data", bus.pop_data, 8'hB0 + 8'(i));
            bus.pop_ready = 1'b1;
            tick();
        end
        bus.pop_ready = 1'b0;
        check("t3_empty_no_c0", bus.pop_valid, 0);

        // async reset to clear the high-water mark
        #2;
        reset = 1'b1;
        #1;
        check("rst2_peak", bus.peak_occupancy, 0);
        reset = 1'b0;
        tick();

        // streaming with pop_ready held high
        bus.pop_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.push_valid = 1'b1;
            bus.push_data  = 8'(i);
            tick();
            check("t4_pop_data", bus.pop_data, 8'(i));
            check("t4_occ", bus.occupancy, 1);
        end
        bus.push_valid = 1'b0;
        tick();
        bus.pop_ready = 1'b0;
        check("t4_occ_end", bus.occupancy, 0);
        check("t4_peak", bus.peak_occupancy, 1);

        // flush beats simultaneous push and pop
        for (int i = 0; i < 3; i++) begin
            bus.push_valid = 1'b1;
            bus.push_data  = 8'h30 + 8'(i);
            tick();
        end
        bus.push_data = 8'h33;
        bus.pop_ready = 1'b1;
        bus.flush     = 1'b1;
        tick();
        bus.push_valid = 1'b0;
        bus.pop_ready  = 1'b0;
        bus.flush      = 1'b0;
        check("t5_occ", bus.occupancy, 0);
        check("t5_pop_valid", bus.pop_valid, 0);
        check("t5_peak", bus.peak_occupancy, 3);
        bus.push_valid = 1'b1;
        bus.push_data  = 8'h44;
        tick();
        bus.push_valid = 1'b0;
        check("t5_after_flush_head", bus.pop_data, 8'h44);
        check("t5_after_flush_occ", bus.occupancy, 1);

        // async reset mid-cycle with two entries held
        bus.push_valid = 1'b1;
        bus.push_data  = 8'h45;
        tick();
        check("t6_occ_before", bus.occupancy, 2);
        #2;
        reset = 1'b1;
        #1;
        check("t6_occ", bus.occupancy, 0);
        check("t6_pop_valid", bus.pop_valid, 0);
        check("t6_busy", bus.busy, 0);
        check("t6_push_ready", bus.push_ready, 1);
        check("t6_peak", bus.peak_occupancy, 0);
        tick();
        check("t6_held_occ", bus.occupancy, 0);
        #2;
        reset = 1'b0;
        bus.push_data = 8'h55;
        tick();
        bus.push_valid = 1'b0;
        check("t6_post_head", bus.pop_data, 8'h55);
        check("t6_post_occ", bus.occupancy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
